// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions.
// Holds the opcode encodings, the bubble instruction word, the rs/rt
// field positions and the Tnew width. The pipeline registers import it.
package mips_defs;

    localparam int TNEW_W = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/tnew_decode.sv
// Combinational opcode -> Tnew decoder.
// Tnew is the number of cycles, counted from E, until the instruction's
// result can be forwarded. The pipeline registers share this decoder.
// Ports:
//   instr  in  32      instruction word
//   tnew   out TNEW_W  2 = lw, 1 = R-type/ori/lui/addiu, 0 = everything else
module tnew_decode
    import mips_defs::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic [31:0]       instr,
    output logic [TNEW_W-1:0] tnew
);

    logic [5:0] opcode;
    assign opcode = instr[OP_MSB:OP_LSB];

    always_comb begin
        tnew = '0;
        if (instr != NOP) begin
            case (opcode)
                OP_LW:    tnew = 2'd2;
                OP_RTYPE,
                OP_ORI,
                OP_LUI,
                OP_ADDIU: tnew = 2'd1;
                default:  tnew = 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/d_e_pipe_reg.sv
// Decode -> Execute pipeline register.
// Captures the D-stage bundle every cycle. It inserts a NOP bubble on a stall
// or a flush, and it holds its contents while the E multi-cycle unit is busy.
// While it holds, W-stage writes refresh the held rs/rt operands.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   D_instr/PC/RS/RT/EXTDATA   incoming D-stage bundle
//   stall, flush, E_busy       hazard/control inputs (priority busy > flush > stall)
//   W_we, W_addr, W_data       W-stage register-file write port (operand refresh)
//   E_instr/PC/RS/RT/EXTDATA   registered E-stage bundle
//   E_valid, E_Tnew            real-instruction flag and result latency for hazard unit
//   bubble_cnt                 bubbles inserted since reset (wraps)
module d_e_pipe_reg
    import mips_defs::*;
#(
    parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       D_instr,
    input  logic [31:0]       D_PC,
    input  logic [31:0]       D_RS_DATA,
    input  logic [31:0]       D_RT_DATA,
    input  logic [31:0]       D_EXTDATA,
    input  logic              stall,
    input  logic              flush,
    input  logic              E_busy,
    input  logic              W_we,
    input  logic [4:0]        W_addr,
    input  logic [31:0]       W_data,
    output logic [31:0]       E_instr,
    output logic [31:0]       E_PC,
    output logic [31:0]       E_RS_DATA,
    output logic [31:0]       E_RT_DATA,
    output logic [31:0]       E_EXTDATA,
    output logic              E_valid,
    output logic [TNEW_W-1:0] E_Tnew,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [31:0]       instr_reg;
    logic [31:0]       pc_reg;
    logic [31:0]       ext_reg;
    logic              valid_reg;
    logic [TNEW_W-1:0] tnew_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [TNEW_W-1:0] d_tnew;
    logic              insert_bubble;
    logic              d_is_nop;

    tnew_decode #(.NOP(NOP_INSTR)) u_tnew_decode (
        .instr (D_instr),
        .tnew  (d_tnew)
    );

    // A stall and a flush in the same cycle produce one bubble.
    assign insert_bubble = !E_busy && (flush || stall);
    assign d_is_nop      = (D_instr == NOP_INSTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            ext_reg   <= '0;
            valid_reg <= 1'b0;
            tnew_reg  <= '0;
            cnt_reg   <= '0;
        end else if (E_busy) begin
            // hold: control fields and counter keep their values
        end else if (insert_bubble) begin
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            ext_reg   <= '0;
            valid_reg <= 1'b0;
            tnew_reg  <= '0;
            cnt_reg   <= cnt_reg + 1'b1;
        end else begin
            instr_reg <= D_instr;
            pc_reg    <= D_PC;
            ext_reg   <= D_EXTDATA;
            valid_reg <= !d_is_nop;
            tnew_reg  <= d_is_nop ? '0 : d_tnew;
        end
    end

    // Operand registers: gi = 0 is rs, gi = 1 is rt. Each one takes a W-stage
    // write aimed at its own source field while the stage is held.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [31:0] opnd_reg;
            logic [31:0] d_opnd;
            logic [4:0]  src_addr;
            logic        refresh;

            assign d_opnd   = (gi == 0) ? D_RS_DATA : D_RT_DATA;
            assign src_addr = (gi == 0) ? instr_reg[RS_MSB:RS_LSB]
                                        : instr_reg[RT_MSB:RT_LSB];
            assign refresh  = valid_reg && W_we && (W_addr != 5'd0) &&
                              (W_addr == src_addr);

            always_ff @(posedge clk) begin
                if (reset) begin
                    opnd_reg <= '0;
                end else if (E_busy) begin
                    if (refresh) begin
                        opnd_reg <= W_data;
                    end
                end else if (insert_bubble) begin
                    opnd_reg <= '0;
                end else begin
                    opnd_reg <= d_opnd;
                end
            end
        end
    endgenerate

    assign E_instr    = instr_reg;
    assign E_PC       = pc_reg;
    assign E_RS_DATA  = g_opnd[0].opnd_reg;
    assign E_RT_DATA  = g_opnd[1].opnd_reg;
    assign E_EXTDATA  = ext_reg;
    assign E_valid    = valid_reg;
    assign E_Tnew     = tnew_reg;
    assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
module tb_d_e_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_instr, D_PC, D_RS_DATA, D_RT_DATA, D_EXTDATA;
    logic        stall, flush, E_busy, W_we;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic [31:0] E_instr, E_PC, E_RS_DATA, E_RT_DATA, E_EXTDATA;
    logic        E_valid;
    logic [1:0]  E_Tnew;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        int          step;
        logic [31:0] instr, pc, rs, rt, ext;
        logic        valid;
        logic [1:0]  tnew;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    d_e_pipe_reg dut (
        .clk(clk), .reset(reset),
        .D_instr(D_instr), .D_PC(D_PC), .D_RS_DATA(D_RS_DATA),
        .D_RT_DATA(D_RT_DATA), .D_EXTDATA(D_EXTDATA),
        .stall(stall), .flush(flush), .E_busy(E_busy),
        .W_we(W_we), .W_addr(W_addr), .W_data(W_data),
        .E_instr(E_instr), .E_PC(E_PC), .E_RS_DATA(E_RS_DATA),
        .E_RT_DATA(E_RT_DATA), .E_EXTDATA(E_EXTDATA),
        .E_valid(E_valid), .E_Tnew(E_Tnew), .bubble_cnt(bubble_cnt)
    );

    // Drive one cycle of inputs on the falling edge.
    task automatic drive(input logic rst, input logic busy, input logic fl,
                         input logic st, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        @(negedge clk);
        reset = rst; E_busy = busy; flush = fl; stall = st;
        D_instr = ins; D_PC = pc; D_RS_DATA = rs; D_RT_DATA = rt; D_EXTDATA = ext;
        W_we = we; W_addr = wa; W_data = wd;
    endtask

    // Push the expected E-stage state after the coming rising edge.
    task automatic expect_e(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] ext, input logic v,
                            input logic [1:0] tn, input logic [31:0] cnt);
        exp_t e;
        step_no++;
        e.step = step_no; e.instr = ins; e.pc = pc; e.rs = rs; e.rt = rt;
        e.ext = ext; e.valid = v; e.tnew = tn; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input int step, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %08h expected %08h", step, name, act, req);
        end
    endtask

    // Monitor: every rising edge with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.step, "E_instr",    E_instr,             e.instr);
                cmp(e.step, "E_PC",       E_PC,                e.pc);
                cmp(e.step, "E_RS_DATA",  E_RS_DATA,           e.rs);
                cmp(e.step, "E_RT_DATA",  E_RT_DATA,           e.rt);
                cmp(e.step, "E_EXTDATA",  E_EXTDATA,           e.ext);
                cmp(e.step, "E_valid",    {31'd0, E_valid},    {31'd0, e.valid});
                cmp(e.step, "E_Tnew",     {30'd0, E_Tnew},     {30'd0, e.tnew});
                cmp(e.step, "bubble_cnt", bubble_cnt,          e.cnt);
                $display("step %0d: instr=%08h pc=%08h rs=%08h rt=%08h ext=%08h v=%0b tnew=%0d cnt=%0d",
                         e.step, E_instr, E_PC, E_RS_DATA, E_RT_DATA, E_EXTDATA,
                         E_valid, E_Tnew, bubble_cnt);
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b1; E_busy = 1'b0; flush = 1'b0; stall = 1'b0;
        D_instr = 32'h8D28_0004; D_PC = 32'h3000; D_RS_DATA = 32'h11;
        D_RT_DATA = 32'h22; D_EXTDATA = 32'h4;
        W_we = 1'b0; W_addr = 5'd0; W_data = 32'h0;

        // reset for two cycles with live D inputs
        drive(1,0,0,0, 32'h8D28_0004, 32'h3000, 32'h11, 32'h22, 32'h4, 0, 0, 0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 0);
        drive(1,0,0,0, 32'h8D28_0004, 32'h3000, 32'h11, 32'h22, 32'h4, 0, 0, 0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 0);
        // lw $8,4($9)
        drive(0,0,0,0, 32'h8D28_0004, 32'h3000, 32'h11, 32'h22, 32'h4, 0, 0, 0);
        expect_e(32'h8D28_0004, 32'h3000, 32'h11, 32'h22, 32'h4, 1, 2, 0);
        // stall with addu $10,$8,$9 in D -> bubble
        drive(0,0,0,1, 32'h0109_5021, 32'h3004, 32'h5, 32'h6, 32'h5021, 0, 0, 0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 1);
        // stall released -> addu loads
        drive(0,0,0,0, 32'h0109_5021, 32'h3004, 32'h5, 32'h6, 32'h5021, 0, 0, 0);
        expect_e(32'h0109_5021, 32'h3004, 32'h5, 32'h6, 32'h5021, 1, 1, 1);
        // mult $8,$9
        drive(0,0,0,0, 32'h0109_0018, 32'h3008, 32'h100, 32'h200, 32'h18, 0, 0, 0);
        expect_e(32'h0109_0018, 32'h3008, 32'h100, 32'h200, 32'h18, 1, 1, 1);
        // busy three cycles, W writes $8 -> rs refreshed, D changes ignored
        for (int i = 0; i < 3; i++) begin
            drive(0,1,0,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 1, 5'd8, 32'hDEAD_BEEF);
            expect_e(32'h0109_0018, 32'h3008, 32'hDEAD_BEEF, 32'h200, 32'h18, 1, 1, 1);
        end
        // busy, W writes $9 -> rt refreshed
        drive(0,1,0,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 1, 5'd9, 32'hCAFE_F00D);
        expect_e(32'h0109_0018, 32'h3008, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h18, 1, 1, 1);
        // busy, W writes $0 -> no change
        drive(0,1,0,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 1, 5'd0, 32'h1234_5678);
        expect_e(32'h0109_0018, 32'h3008, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h18, 1, 1, 1);
        // busy, write enable low -> no change
        drive(0,1,0,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 0, 5'd8, 32'h0000_AAAA);
        expect_e(32'h0109_0018, 32'h3008, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h18, 1, 1, 1);
        // busy + flush -> hold wins, no count
        drive(0,1,1,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 0, 5'd0, 32'h0);
        expect_e(32'h0109_0018, 32'h3008, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h18, 1, 1, 1);
        // flush alone -> bubble
        drive(0,0,1,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 0, 5'd0, 32'h0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 2);
        // ori
        drive(0,0,0,0, 32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 0, 5'd0, 32'h0);
        expect_e(32'h3508_FFFF, 32'h300C, 32'h7, 32'h8, 32'hFFFF, 1, 1, 2);
        // stall + flush together -> single bubble
        drive(0,0,1,1, 32'hAD28_0000, 32'h3010, 32'h1, 32'h2, 32'h0, 0, 5'd0, 32'h0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 3);
        // sw -> Tnew 0
        drive(0,0,0,0, 32'hAD28_0000, 32'h3010, 32'h1, 32'h2, 32'h0, 0, 5'd0, 32'h0);
        expect_e(32'hAD28_0000, 32'h3010, 32'h1, 32'h2, 32'h0, 1, 0, 3);
        // NOP loaded from D -> invalid, Tnew 0, fields copied
        drive(0,0,0,0, 32'h0000_0000, 32'h3014, 32'h3, 32'h4, 32'h0, 0, 5'd0, 32'h0);
        expect_e(32'h0, 32'h3014, 32'h3, 32'h4, 32'h0, 0, 0, 3);
        // lui
        drive(0,0,0,0, 32'h3C01_1234, 32'h3018, 32'h9, 32'hA, 32'h1234, 0, 5'd0, 32'h0);
        expect_e(32'h3C01_1234, 32'h3018, 32'h9, 32'hA, 32'h1234, 1, 1, 3);
        // reset during hold -> reset values
        drive(1,1,0,0, 32'h2508_0001, 32'h301C, 32'hB, 32'hC, 32'h1, 1, 5'd1, 32'h5555_5555);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 0);
        // hold of the cleared state
        drive(0,1,0,0, 32'h2508_0001, 32'h301C, 32'hB, 32'hC, 32'h1, 0, 5'd0, 32'h0);
        expect_e(32'h0, 0, 0, 0, 0, 0, 0, 0);
        // addiu
        drive(0,0,0,0, 32'h2508_0001, 32'h301C, 32'hB, 32'hC, 32'h1, 0, 5'd0, 32'h0);
        expect_e(32'h2508_0001, 32'h301C, 32'hB, 32'hC, 32'h1, 1, 1, 0);

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
